// File: rtl/accum_pkg.sv
// accum_pkg: shared constants and types for the accum_seq accumulator.
//   MODE_W       width of the Mode field (bit 3 selects ALU/shifter, bits 2:0 select the op)
//   OP_*         ALU op codes (Mode[3] = 0)
//   SH_*         iterative shifter op codes (Mode[3] = 1); codes above SH_ROR pass operand A
//   state_t      sequencer states
//   is_iter_shift  true for the shifter ops that run one bit per step
package accum_pkg;

  localparam int unsigned MODE_W = 4;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_NOT   = 3'd5;
  localparam logic [2:0] OP_PASSB = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  localparam logic [2:0] SH_SLL = 3'd0;
  localparam logic [2:0] SH_SRL = 3'd1;
  localparam logic [2:0] SH_SRA = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_iter_shift(input logic [MODE_W-1:0] mode);
    return mode[3] && (mode[2:0] <= SH_ROR);
  endfunction

endpackage

// File: rtl/accum_seq_if.sv
// accum_seq_if: operand/control/status bundle of the accum_seq accumulator.
//   master: drives start, clr, use_acc, mode, a, b, cin, shamt; reads the status outputs
//   slave : the accumulator; drives res (accumulator), co, of, of_sticky, busy, done
interface accum_seq_if #(
  parameter int unsigned WIDTH = 8
);
  import accum_pkg::*;

  localparam int unsigned SHW = $clog2(WIDTH);

  logic              start;
  logic              clr;
  logic              use_acc;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic [SHW-1:0]    shamt;

  logic [WIDTH-1:0]  res;
  logic              co;
  logic              of;
  logic              of_sticky;
  logic              busy;
  logic              done;

  modport master (
    output start, clr, use_acc, mode, a, b, cin, shamt,
    input  res, co, of, of_sticky, busy, done
  );

  modport slave (
    input  start, clr, use_acc, mode, a, b, cin, shamt,
    output res, co, of, of_sticky, busy, done
  );

endinterface

// File: rtl/alu_step.sv
// alu_step: combinational datapath shared by every ALU op and every single-bit shift step.
//   mode     op select (Mode[3]=0 ALU, 1 shifter)
//   op_a, b  operands; cin carry in (ADD/SUB only)
//   res      result; co carry out / bit shifted out; of signed overflow (ADD/SUB only)
module alu_step
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  output logic [WIDTH-1:0]  res,
  output logic              co,
  output logic              of
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    // SUB is opA + ~B + Cin so one adder serves both
    addend = (mode[2:0] == OP_SUB) ? ~b : b;
    sum    = {1'b0, op_a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    res    = op_a;
    co     = 1'b0;
    of     = 1'b0;
    if (!mode[3]) begin
      unique case (mode[2:0])
        OP_ADD, OP_SUB: begin
          res = sum[WIDTH-1:0];
          co  = sum[WIDTH];
          of  = (op_a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        end
        OP_AND:   res = op_a & b;
        OP_OR:    res = op_a | b;
        OP_XOR:   res = op_a ^ b;
        OP_NOT:   res = ~op_a;
        OP_PASSB: res = b;
        OP_PASSA: res = op_a;
      endcase
    end else begin
      case (mode[2:0])
        SH_SLL: begin
          res = {op_a[WIDTH-2:0], 1'b0};
          co  = op_a[WIDTH-1];
        end
        SH_SRL: begin
          res = {1'b0, op_a[WIDTH-1:1]};
          co  = op_a[0];
        end
        SH_SRA: begin
          res = {op_a[WIDTH-1], op_a[WIDTH-1:1]};
          co  = op_a[0];
        end
        SH_ROL: begin
          res = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
          co  = op_a[WIDTH-1];
        end
        SH_ROR: begin
          res = {op_a[0], op_a[WIDTH-1:1]};
          co  = op_a[0];
        end
        default: res = op_a;
      endcase
    end
  end

endmodule

// File: rtl/accum_seq.sv
// accum_seq: WIDTH-bit accumulator with single-cycle ALU ops and iterative (bit-per-cycle) shifts.
//   Clk    rising-edge clock
//   Reset  synchronous active-high reset
//   bus    accum_seq_if slave: start/clr/use_acc/mode/a/b/cin/shamt in;
//          res (accumulator), co, of, of_sticky, busy, done out
module accum_seq
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic        Clk,
  input logic        Reset,
  accum_seq_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              co_q, co_d;
  logic              of_q, of_d;
  logic              ofs_q, ofs_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  op_a;
  logic [MODE_W-1:0] step_mode;
  logic [WIDTH-1:0]  step_a;
  logic [WIDTH-1:0]  step_res;
  logic              step_co;
  logic              step_of;

  assign op_a = bus.use_acc ? acc_q : bus.a;

  // While shifting, the shared step unit works on the private work register with the
  // mode captured at launch, so live inputs cannot disturb an op in flight.
  always_comb begin
    step_mode = bus.mode;
    step_a    = op_a;
    if (state_q == SHIFT) begin
      step_mode = mode_q;
      step_a    = work_q;
    end
  end

  alu_step #(
    .WIDTH(WIDTH)
  ) u_alu_step (
    .mode(step_mode),
    .op_a(step_a),
    .b   (bus.b),
    .cin (bus.cin),
    .res (step_res),
    .co  (step_co),
    .of  (step_of)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    co_d    = co_q;
    of_d    = of_q;
    ofs_d   = ofs_q;
    done_d  = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      acc_d   = '0;
      work_d  = '0;
      cnt_d   = '0;
      co_d    = 1'b0;
      of_d    = 1'b0;
      ofs_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_iter_shift(bus.mode) && (bus.shamt == '0)) begin
              acc_d  = op_a;
              co_d   = 1'b0;
              of_d   = 1'b0;
              done_d = 1'b1;
            end else if (is_iter_shift(bus.mode) && (bus.shamt > SHW'(1))) begin
              work_d  = step_res;
              cnt_d   = bus.shamt - SHW'(1);
              mode_d  = bus.mode;
              state_d = SHIFT;
            end else begin
              acc_d  = step_res;
              co_d   = step_co;
              of_d   = step_of;
              ofs_d  = ofs_q | step_of;
              done_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt_q > SHW'(1)) begin
            work_d = step_res;
            cnt_d  = cnt_q - SHW'(1);
          end else begin
            acc_d   = step_res;
            co_d    = step_co;
            of_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      co_q    <= 1'b0;
      of_q    <= 1'b0;
      ofs_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      co_q    <= co_d;
      of_q    <= of_d;
      ofs_q   <= ofs_d;
      done_q  <= done_d;
    end
  end

  assign bus.res       = acc_q;
  assign bus.co        = co_q;
  assign bus.of        = of_q;
  assign bus.of_sticky = ofs_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: directed, table-driven bench for accum_seq at WIDTH=8.
module tb_accum_seq;
  import accum_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  accum_seq_if #(.WIDTH(WIDTH)) bus ();

  accum_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic       use_acc;
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] shamt;
    logic [7:0] res;
    logic       co;
    logic       of;
    logic       ofs;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string name, input logic [7:0] res, input logic co,
                              input logic of, input logic ofs, input logic busy,
                              input logic done);
    check({name, ".res"}, 32'(bus.res), 32'(res));
    check({name, ".co"}, 32'(bus.co), 32'(co));
    check({name, ".of"}, 32'(bus.of), 32'(of));
    check({name, ".ofs"}, 32'(bus.of_sticky), 32'(ofs));
    check({name, ".busy"}, 32'(bus.busy), 32'(busy));
    check({name, ".done"}, 32'(bus.done), 32'(done));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.clr     = 1'b0;
    bus.use_acc = 1'b0;
    bus.mode    = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.cin     = 1'b0;
    bus.shamt   = '0;
  endtask

  task automatic launch(input logic use_acc, input logic [3:0] mode, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [2:0] shamt);
    bus.start   = 1'b1;
    bus.use_acc = use_acc;
    bus.mode    = mode;
    bus.a       = a;
    bus.b       = b;
    bus.cin     = cin;
    bus.shamt   = shamt;
  endtask

  initial begin
    int cycles;
    int dones;

    //            use  mode             a      b      cin   sh    res    co    of    ofs
    vecs[0]  = '{1'b0, {1'b0, OP_ADD},   8'h7F, 8'h01, 1'b0, 3'd0, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, {1'b0, OP_SUB},   8'h00, 8'h01, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, {1'b0, OP_PASSB}, 8'h00, 8'h05, 1'b0, 3'd0, 8'h05, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, {1'b0, OP_ADD},   8'hEE, 8'h03, 1'b0, 3'd0, 8'h08, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, {1'b0, OP_ADD},   8'hEE, 8'h03, 1'b0, 3'd0, 8'h0B, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, {1'b0, OP_ADD},   8'hEE, 8'h03, 1'b0, 3'd0, 8'h0E, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, {1'b0, OP_AND},   8'hF0, 8'h3C, 1'b1, 3'd0, 8'h30, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, {1'b0, OP_OR},    8'hF0, 8'h0F, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, {1'b0, OP_XOR},   8'hFF, 8'h0F, 1'b0, 3'd0, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, {1'b0, OP_NOT},   8'h00, 8'h00, 1'b0, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, {1'b0, OP_PASSA}, 8'hA5, 8'h11, 1'b0, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, {1'b0, OP_SUB},   8'h00, 8'h05, 1'b1, 3'd0, 8'hA0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, {1'b0, OP_ADD},   8'hFF, 8'h01, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, {1'b0, OP_SUB},   8'h80, 8'h01, 1'b1, 3'd0, 8'h7F, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, {1'b1, SH_SRL},   8'h03, 8'h00, 1'b0, 3'd1, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, {1'b1, SH_ROR},   8'h01, 8'h00, 1'b0, 3'd1, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 4'hD,             8'h3C, 8'h00, 1'b0, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, {1'b1, SH_SLL},   8'h81, 8'h00, 1'b0, 3'd0, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, {1'b0, OP_ADD},   8'h10, 8'h20, 1'b1, 3'd0, 8'h31, 1'b0, 1'b0, 1'b1};

    // Reset in the middle of random activity
    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.start   = 1'($urandom_range(0, 1));
      bus.use_acc = 1'($urandom_range(0, 1));
      bus.mode    = 4'($urandom);
      bus.a       = 8'($urandom);
      bus.b       = 8'($urandom);
      bus.cin     = 1'($urandom_range(0, 1));
      bus.shamt   = 3'($urandom);
      step();
    end
    bus.mode  = {1'b1, SH_SLL};
    bus.a     = 8'h7F;
    bus.shamt = 3'd7;
    bus.start = 1'b1;
    step();
    Reset = 1'b1;
    step();
    expect_state("reset1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    Reset = 1'b0;
    idle_inputs();
    step();
    expect_state("reset2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle ops, back to back
    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].use_acc, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].shamt);
      step();
      expect_state($sformatf("vec%0d", i), vecs[i].res, vecs[i].co, vecs[i].of, vecs[i].ofs,
                   1'b0, 1'b1);
    end
    idle_inputs();
    step();
    check("vec_tail.done", 32'(bus.done), 32'd0);

    // SRA of 0x90 by 3 from the accumulator
    launch(1'b0, {1'b0, OP_PASSB}, 8'h00, 8'h90, 1'b0, 3'd0);
    step();
    launch(1'b1, {1'b1, SH_SRA}, 8'h00, 8'h00, 1'b0, 3'd3);
    step();
    launch(1'b0, {1'b0, OP_PASSB}, 8'h33, 8'h44, 1'b1, 3'd1);
    bus.start = 1'b0;
    expect_state("sra.e0", 8'h90, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_state("sra.e1", 8'h90, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_state("sra.e2", 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    launch(1'b0, {1'b1, SH_ROL}, 8'h81, 8'h00, 1'b0, 3'd1);
    step();
    expect_state("rol1", 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_inputs();

    // SLL by 7 with Start held and operands changing while busy
    launch(1'b0, {1'b1, SH_SLL}, 8'h03, 8'h00, 1'b0, 3'd7);
    step();
    check("sll7.busy", 32'(bus.busy), 32'd1);
    launch(1'b0, {1'b0, OP_ADD}, 8'hFF, 8'hFF, 1'b1, 3'd1);
    cycles = 1;
    while (!bus.done && cycles < 20) begin
      step();
      cycles++;
    end
    idle_inputs();
    check("sll7.latency", 32'(cycles), 32'd7);
    expect_state("sll7.end", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    expect_state("sll7.after", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // SLL by 7 cut short by Reset on the third edge
    launch(1'b0, {1'b1, SH_SLL}, 8'h01, 8'h00, 1'b0, 3'd7);
    step();
    bus.start = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    expect_state("sll7rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("sll7rst.no_done", 32'(dones), 32'd0);

    // Clr aborts a shift in progress
    launch(1'b0, {1'b1, SH_ROL}, 8'h01, 8'h00, 1'b0, 3'd6);
    step();
    bus.start = 1'b0;
    step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    expect_state("clr_shift", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("clr_shift.no_done", 32'(dones), 32'd0);

    // Clr together with Start drops the op and clears the sticky flag
    launch(1'b0, {1'b0, OP_ADD}, 8'h7F, 8'h01, 1'b0, 3'd0);
    step();
    expect_state("ovf", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    launch(1'b0, {1'b0, OP_ADD}, 8'h01, 8'h01, 1'b0, 3'd0);
    bus.clr = 1'b1;
    step();
    idle_inputs();
    expect_state("clr_start", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_state("clr_start.next", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Shamt = 0 shift loads operand A unchanged
    launch(1'b0, {1'b1, SH_SRL}, 8'h5A, 8'h00, 1'b0, 3'd0);
    step();
    idle_inputs();
    expect_state("srl0", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("srl0.done_clear", 32'(bus.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_seq.md
Name: accum_seq

Overview:
- Parametrised successor to the 4-bit ALU/shifter accumulator: WIDTH-bit datapath with an accumulator register.
- Operand A is selectable as the external input or the accumulator itself, so chained ops accumulate without external feedback.
- Shifts are multi-bit and iterative (one bit per cycle) under a Start/Busy/Done handshake.
- Adds carry-out, a per-op overflow flag, a sticky overflow flag and a synchronous clear.
- Sits where the 4-bit accumulator sits, behind the same Mode encoding.

Parameters:
- WIDTH, 8, datapath/accumulator width (>=4).
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- Clk       in   1      rising-edge clock; the only clock
- Reset     in   1      reset, synchronous, active-high
- Start     in   1      launch op this edge (ignored while Busy)
- Clr       in   1      synchronous clear of Acc/flags; aborts any op
- UseAcc    in   1      1: operand A = accumulator; 0: operand A = A port
- Mode      in   4      Mode[3]=0 ALU, Mode[3]=1 shifter; Mode[2:0] = op
- A         in   WIDTH  external operand A
- B         in   WIDTH  operand B
- Cin       in   1      carry in (ADD/SUB only)
- Shamt     in   SHW    shift amount, sampled with Start
- Res       out  WIDTH  accumulator contents
- Co        out  1      carry/last-bit-out of last completed op
- Of        out  1      signed overflow of last completed op
- OfSticky  out  1      OR of Of since last Reset/Clr
- Busy      out  1      multi-cycle shift in progress
- Done      out  1      one-cycle pulse after Acc update

Behaviour:
- Reset (sync, high) or Clr: Res=0, Co=0, Of=0, OfSticky=0, Busy=0, Done=0, FSM->IDLE, any shift aborted.
- Priority: Reset > Clr > Start. Start coincident with Clr is dropped.
- ALU ops (Mode[3]=0), opA = UseAcc ? Acc : A:
  - 000 ADD: opA+B+Cin; Co = carry out; Of = signed overflow.
  - 001 SUB: opA+~B+Cin (Cin=1 gives a plain subtract); Co=0 means borrow; Of = signed overflow.
  - 010 AND; 011 OR; 100 XOR; 101 NOT opA; 110 PASS B (load); 111 PASS opA.
  - Logic/pass ops: Co=0, Of=0.
- Shifter ops (Mode[3]=1), one bit per step:
  - 000 SLL; 001 SRL; 010 SRA; 011 ROL; 100 ROR; 101-111 PASS opA (single cycle, Co=0).
  - Co = bit shifted/rotated out on the final step; Of=0.
- Timing (E0 = edge sampling Start in IDLE):
  - ALU ops, PASS, and shifts with Shamt<=1: Acc/Co/Of written at E0; Done=1 for the following cycle; Busy stays 0.
  - Shamt=0: Acc=opA, Co=0.
  - Shift with Shamt=k>=2:
    - At E0: work <= step(opA), cnt <= k-1, FSM->SHIFT, Busy=1.
    - Each SHIFT edge with cnt>1: work <= step(work), cnt--.
    - At the edge with cnt==1: Acc <= step(work), Co updated, FSM->IDLE, Busy->0, Done pulse.
    - Total latency k edges; Busy high k-1 cycles.
  - Res shows the committed Acc only; no intermediate values during SHIFT.
- Operand latching: opA, B, Mode, Shamt and Cin are latched at E0. Input changes during Busy have no effect.
- Start while Busy: ignored, no queuing. Start in the cycle after Done is accepted normally (back-to-back one op per cycle for ALU ops).
- OfSticky set on any committed Of=1; cleared only by Reset/Clr.
- FSM states: IDLE, SHIFT. No other states.

Decomposition:
- Package accum_pkg holds:
  - Mode op constants (OP_ADD..OP_PASSA, SH_SLL..SH_ROR);
  - FSM state typedef {IDLE, SHIFT};
  - MODE_W=4.
- One combinational sub-module alu_step (WIDTH param):
  - computes the ALU result plus Co/Of, or one shift step plus bit-out;
  - instantiated once in accum_seq, shared by ALU ops and every shift step.
- Registers and FSM live in accum_seq.

Test Plan (WIDTH=8):
- Reset held 2 cycles mid-random activity -> Res=0x00, Co=Of=OfSticky=Busy=Done=0 after the next edge.
- ADD UseAcc=0 A=0x7F B=0x01 Cin=0 -> Res=0x80, Of=1, Co=0, OfSticky=1, Done pulse 1 cycle. Then SUB A=0x00 B=0x01 Cin=1 -> Res=0xFF, Co=0, Of=0, OfSticky still 1.
- PASS B=0x05, then 3x ADD UseAcc=1 B=0x03 on consecutive cycles -> Res 0x08, 0x0B, 0x0E; three Done pulses; Busy never set.
- Acc=0x90, SRA UseAcc=1 Shamt=3 -> Busy high 2 cycles, Res stays 0x90 until the 3rd edge, then Res=0xF2, Co=0. ROL 0x81 Shamt=1 -> Res=0x03, Co=1, 1-cycle.
- During SLL Shamt=7: assert Start with new operands -> ignored, result from the original op. A second SLL Shamt=7 with Reset asserted at cycle 3 -> Res=0, Busy=0, no Done.
- Clr and Start (ADD) in the same cycle with OfSticky=1 -> Res=0, OfSticky=0, no Done. Shamt=0 SRL A=0x5A -> Res=0x5A, Co=0, Done next cycle.
